// File: rtl/xprog_loader_pkg.sv
// Shared widths, FSM state encoding and helpers for the program-RAM DMA loader.
package xprog_loader_pkg;

  localparam int PROG_ADDR_W = 10;
  localparam int PROG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4,
    ST_FIN  = 3'd5
  } xprog_state_e;

  function automatic logic is_busy_state(input xprog_state_e s);
    return (s == ST_LOAD) || (s == ST_RD) || (s == ST_CAP) || (s == ST_OUT);
  endfunction

endpackage

// File: rtl/xprog_loader_if.sv
// Command, stream and RAM DMA-port signals of the program loader.
// master = loader side, slave = host link / RAM / controller side.
interface xprog_loader_if
  import xprog_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W
) ();

  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  logic              cpu_sel;
  logic              dma_sel;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_data_in;
  logic [DATA_W-1:0] dma_data_out;

  modport master (
    input  start, dir, base_addr, len, in_valid, in_data, out_ready, cpu_sel, dma_data_out,
    output busy, done, in_ready, out_valid, out_data, dma_sel, dma_we, dma_addr, dma_data_in
  );

  modport slave (
    output start, dir, base_addr, len, in_valid, in_data, out_ready, cpu_sel, dma_data_out,
    input  busy, done, in_ready, out_valid, out_data, dma_sel, dma_we, dma_addr, dma_data_in
  );

endinterface

// File: rtl/xprog_loader.sv
// DMA-side master for the program RAM: LOAD copies a valid/ready stream into RAM,
// DUMP reads a RAM range back out as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | writing stream words into RAM, one per accepted beat
// RD    | read request on the DMA port, retried while the controller owns it
// CAP   | RAM read data available, captured into the output register
// OUT   | output word presented, waiting for out_ready
// FIN   | one-cycle done pulse
module xprog_loader
  import xprog_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W
) (
  input logic            clk,
  input logic            rst,
  xprog_loader_if.master bus
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  xprog_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              busy, done, in_ready;
  logic              dma_sel, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_data_in;
  logic              last_word;

  assign last_word = (cnt_q == CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy        = is_busy_state(state_q);
    done        = 1'b0;
    in_ready    = 1'b0;
    dma_sel     = 1'b0;
    dma_we      = 1'b0;
    dma_addr    = '0;
    dma_data_in = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          cnt_d  = bus.len;
          if (bus.len == '0)  state_d = ST_FIN;
          else if (bus.dir)   state_d = ST_RD;
          else                state_d = ST_LOAD;
        end
      end

      // The controller owns the shared port whenever cpu_sel is high.
      ST_LOAD: begin
        in_ready = !bus.cpu_sel;
        if (bus.in_valid && !bus.cpu_sel) begin
          dma_sel     = 1'b1;
          dma_we      = 1'b1;
          dma_addr    = addr_q;
          dma_data_in = bus.in_data;
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (last_word) state_d = ST_FIN;
        end
      end

      ST_RD: begin
        dma_sel  = 1'b1;
        dma_addr = addr_q;
        if (!bus.cpu_sel) state_d = ST_CAP;
      end

      ST_CAP: begin
        out_data_d  = bus.dma_data_out;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q - 1'b1;
          state_d     = last_word ? ST_FIN : ST_RD;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.dma_sel     = dma_sel;
  assign bus.dma_we      = dma_we;
  assign bus.dma_addr    = dma_addr;
  assign bus.dma_data_in = dma_data_in;

endmodule

// File: tb/tb_xprog_loader.sv
// Randomized bench for xprog_loader: RAM model with controller priority, reference
// memory image updated per accepted word, and expected dump streams from that image.
module tb_xprog_loader;
  import xprog_loader_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill = 1'b0;
  always #5 clk = ~clk;

  xprog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  xprog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int viol = 0, dma_act = 0, reads = 0, done_cnt = 0;

  // Program RAM: controller has priority, registered read data.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (bus.dma_sel && !bus.cpu_sel) begin
      if (bus.dma_we) mem[bus.dma_addr] <= bus.dma_data_in;
      else            bus.dma_data_out  <= mem[bus.dma_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dma_sel && bus.dma_we && bus.cpu_sel)               viol++;
      if (bus.dma_we && !bus.dma_sel)                              viol++;
      if (!bus.dma_sel && (bus.dma_addr != '0 || bus.dma_data_in != '0)) viol++;
      if (bus.in_ready && bus.cpu_sel)                             viol++;
      if (bus.done && bus.busy)                                    viol++;
      if (bus.dma_sel)                                             dma_act++;
      if (bus.dma_sel && !bus.dma_we && !bus.cpu_sel)              reads++;
      if (bus.done)                                                done_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ram_diff();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // All tasks start and end at posedge+1 with the DUT idle.
  task automatic issue(input logic d, input int base, input int n);
    bus.start     = 1'b1;
    bus.dir       = d;
    bus.base_addr = AW'(base);
    bus.len       = (AW+1)'(n);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.dir       = 1'($urandom_range(0, 1));
    bus.base_addr = AW'($urandom);
    bus.len       = (AW+1)'($urandom);
  endtask

  task automatic finish_op(input string tag, input int d0, input int v0);
    @(negedge clk);
    check_val({tag, "_done"}, {bus.done, bus.busy}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({tag, "_idle"}, {bus.done, bus.busy}, 2'b00);
    check_val({tag, "_done_cnt"}, done_cnt - d0, 1);
    check_val({tag, "_viol"}, viol - v0, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int base, input int n, input int stall_at,
                          input bit gaps, input bit inject);
    int idx = 0, cyc = 0, bad_busy = 0;
    int d0 = done_cnt, v0 = viol;
    bit acc;
    logic [DW-1:0] w;
    issue(1'b0, base, n);
    w = $urandom;
    while (idx < n && cyc < 8 * n + 50) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? w : $urandom;
      bus.cpu_sel  = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      if (inject && cyc == 2) begin
        bus.start = 1'b1;
        bus.dir   = 1'b1;
        bus.len   = (AW+1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (!bus.busy) bad_busy++;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ref_mem[(base + idx) % DEPTH] = w;
        idx++;
        w = $urandom;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.cpu_sel  = 1'b0;
    bus.start    = 1'b0;
    check_val("load_cnt", idx, n);
    check_val("load_busy", bad_busy, 0);
    if (stall_at < 0 && !gaps) check_val("load_tput", cyc, n);
    finish_op("load", d0, v0);
    check_val("load_ram", ram_diff(), 0);
  endtask

  task automatic run_dump(input int base, input int n, input bit stall,
                          input bit hold, input bit rnd);
    int k = 0, cyc = 0, unstable = 0, hold_left = 0, cpu_left = 0;
    int d0 = done_cnt, v0 = viol, r0 = reads;
    bit hold_used = !hold, stall_used = !stall;
    bit prev_valid = 1'b0, prev_acc = 1'b0, acc, rd_seen;
    logic [DW-1:0] prev_data = '0;
    issue(1'b1, base, n);
    while (k < n && cyc < 20 * n + 100) begin
      bus.out_ready = (hold_left > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.cpu_sel   = (cpu_left > 0);
      if (hold_left > 0) hold_left--;
      if (cpu_left > 0)  cpu_left--;
      @(negedge clk);
      if (prev_valid && !prev_acc && (!bus.out_valid || bus.out_data !== prev_data)) unstable++;
      acc = bus.out_valid && bus.out_ready;
      if (acc) begin
        check_val("dump_data", bus.out_data, ref_mem[(base + k) % DEPTH]);
        k++;
      end
      prev_valid = bus.out_valid;
      prev_data  = bus.out_data;
      prev_acc   = acc;
      rd_seen    = bus.dma_sel && !bus.dma_we && !bus.cpu_sel;
      if (rd_seen && !hold_used && k == 0) begin
        hold_left = 12;
        hold_used = 1'b1;
      end
      if (rd_seen && !stall_used && k == 1) begin
        cpu_left   = 5;
        stall_used = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.cpu_sel   = 1'b0;
    check_val("dump_cnt", k, n);
    check_val("dump_stable", unstable, 0);
    if (!stall && !hold && !rnd) check_val("dump_tput", cyc, 3 * n);
    finish_op("dump", d0, v0);
    check_val("dump_reads", reads - r0, n);
  endtask

  task automatic run_len0(input logic d);
    int a0 = dma_act, d0 = done_cnt;
    issue(d, $urandom_range(0, DEPTH - 1), 0);
    @(negedge clk);
    check_val("len0_done", {bus.done, bus.busy}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("len0_idle", {bus.done, bus.busy}, 2'b00);
    check_val("len0_dma", dma_act - a0, 0);
    check_val("len0_done_cnt", done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                              bus.dma_sel, bus.dma_we}, 6'b0);
    check_val({tag, "_dma_addr"}, bus.dma_addr, 0);
    check_val({tag, "_dma_din"}, bus.dma_data_in, 0);
    check_val({tag, "_out_data"}, bus.out_data, 0);
  endtask

  initial begin
    int base, n, stall_at, d0;
    logic [DW-1:0] w;
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.cpu_sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;

    run_load(32'h010, 4, -1, 1'b0, 1'b0);
    run_dump(32'h010, 4, 1'b0, 1'b0, 1'b0);
    run_dump(32'h3FE, 4, 1'b0, 1'b0, 1'b0);
    run_load(32'h3FD, 6, 2, 1'b0, 1'b1);
    run_dump(32'h3FC, 8, 1'b1, 1'b1, 1'b0);
    run_len0(1'b0);
    run_len0(1'b1);

    for (int t = 0; t < 6; t++) begin
      base     = $urandom_range(0, DEPTH - 1);
      n        = $urandom_range(1, 40);
      stall_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n)) : -1;
      run_load(base, n, stall_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_dump(base, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    run_load(32'h155, DEPTH, -1, 1'b1, 1'b0);
    run_dump(32'h200, DEPTH, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a load: three words land, then everything clears.
    d0   = done_cnt;
    base = 32'h200;
    issue(1'b0, base, 8);
    w = $urandom;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(posedge clk); #1;
      ref_mem[base + i] = w;
      w = $urandom;
    end
    bus.in_data = w;
    #3 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_ram", ram_diff(), 0);
    check_val("midrst_no_done", done_cnt - d0, 0);
    run_load(32'h100, 5, -1, 1'b0, 1'b0);
    run_dump(32'h1FE, 8, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
